// File: rtl/fifo_egress_reader_pkg.sv
// rtl/fifo_egress_reader_pkg.sv - element layout, egress FSM states and skid entry type
package pf_egress_pkg;

    localparam int DATA_W    = 16;
    localparam int SOP_BIT   = 16;
    localparam int EOP_BIT   = 17;
    localparam int EMPTY_BIT = 18;

    typedef enum logic {IDLE, FRAME} egress_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              empty;
    } skid_entry_t;

    function automatic skid_entry_t el_to_entry(input logic [EMPTY_BIT:0] el);
        skid_entry_t e;
        e.data  = el[DATA_W-1:0];
        e.sop   = el[SOP_BIT];
        e.eop   = el[EOP_BIT];
        e.empty = el[EMPTY_BIT];
        return e;
    endfunction

endpackage

// File: rtl/fifo_egress_reader_if.sv
// rtl/fifo_egress_reader_if.sv - FIFO read-side and Avalon-ST source interfaces
interface fifo_rd_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int W_EL       = 20
);
    logic                  fifo_ren;
    logic [W_EL-1:0]       fifo_rdata;
    logic                  fifo_empty;
    logic [ADDR_WIDTH:0]   fifo_rptr;
    logic [ADDR_WIDTH:0]   commit_ptr;

    modport master (output fifo_ren, input fifo_rdata, fifo_empty, fifo_rptr, commit_ptr);
    modport slave  (input fifo_ren, output fifo_rdata, fifo_empty, fifo_rptr, commit_ptr);
endinterface

interface avst_src_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        out_empty;

    modport master (output out_data, out_valid, out_sop, out_eop, out_empty, input out_ready);
    modport slave  (input out_data, out_valid, out_sop, out_eop, out_empty, output out_ready);
endinterface

// File: rtl/fifo_egress_reader_skid_buf2.sv
// rtl/fifo_egress_reader_skid_buf2.sv - 2-entry order-preserving skid buffer with flush
module skid_buf2
    import pf_egress_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  skid_entry_t data_i,
    output logic        valid_o,
    output skid_entry_t head_o,
    output logic [1:0]  occ_o
);

    skid_entry_t ent0_q, ent0_d;
    skid_entry_t ent1_q, ent1_d;
    logic [1:0]  occ_q, occ_d;
    logic        do_pop, do_push;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        occ_d   = occ_q;
        do_pop  = pop_i && (occ_q != 2'd0);
        do_push = push_i && ((occ_q != 2'd2) || do_pop);
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_d = data_i;
                    else               ent1_d = data_i;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Head leaves and the new element joins the tail; occupancy is unchanged.
                    if (occ_q == 2'd1) begin
                        ent0_d = data_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign head_o  = ent0_q;
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_egress_reader.sv
// rtl/fifo_egress_reader.sv - drains committed frames from fifo_sync onto an Avalon-ST source
module fifo_egress_reader
    import pf_egress_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int W_EL       = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    fifo_rd_if.master  fifo,
    avst_src_if.master src,
    input  logic       flush,
    output logic       drop_pulse,
    output logic       frame_err
);

    egress_state_t state_q, state_d;
    logic          inflight_q, inflight_d;
    logic          pop, push, issue;
    logic          skid_valid;
    logic [1:0]    occ;
    skid_entry_t   head, ret_el;
    logic          unused_rsvd;

    assign unused_rsvd = &{1'b0, fifo.fifo_rdata[W_EL-1:EMPTY_BIT+1]};
    assign ret_el      = el_to_entry(fifo.fifo_rdata[EMPTY_BIT:0]);
    assign pop         = skid_valid && src.out_ready;

    // Reads are bounded by the commit pointer and by skid space net of this cycle's pop.
    assign issue = reset_n && !flush && !fifo.fifo_empty
                && (fifo.fifo_rptr != fifo.commit_ptr)
                && (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d    = state_q;
        inflight_d = issue;
        push       = 1'b0;
        drop_pulse = 1'b0;
        frame_err  = 1'b0;
        if (inflight_q && !flush) begin
            case (state_q)
                IDLE: begin
                    if (ret_el.sop) begin
                        push    = 1'b1;
                        state_d = ret_el.eop ? IDLE : FRAME;
                    end else begin
                        drop_pulse = 1'b1;
                    end
                end
                FRAME: begin
                    push      = 1'b1;
                    frame_err = ret_el.sop;
                    if (ret_el.eop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    skid_buf2 u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (ret_el),
        .valid_o (skid_valid),
        .head_o  (head),
        .occ_o   (occ)
    );

    assign fifo.fifo_ren = issue;
    assign src.out_valid = skid_valid;
    assign src.out_data  = skid_valid ? head.data  : 16'h0000;
    assign src.out_sop   = skid_valid ? head.sop   : 1'b0;
    assign src.out_eop   = skid_valid ? head.eop   : 1'b0;
    assign src.out_empty = skid_valid ? head.empty : 1'b0;

endmodule
